spi_slave_resp: RTL and testbench

Standalone SPI slave (responder) for the far end of the link driven by the SPI master. It oversamples the external SS, SCK and MOSI lines on the system clock, shifts one 8-bit frame per SS-low window, and returns a preloaded byte on MISO. It gives the user side a one-deep transmit buffer, a receive data register, the SPIF completion flag and an overrun flag.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_resp.sv | 215 +++++++++++++++++++++
 tb/tb_spi_slave_resp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width default and the frame-level state encoding.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign sync = sync_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave_resp.sv
// SPI slave responder: oversamples SS/SCK/MOSI on clk, shifts one frame per SS-low window
// and returns a preloaded byte on MISO, with SPIF/OVR status and a one-deep tx buffer.
module spi_slave_resp
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPE,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              LSBFE,
  input  logic              SS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              SPIF,
  output logic              OVR,
  input  logic              spif_clr
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Input conditioning
  logic ss_sync, ss_rise, ss_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SS),
    .sync (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCK),
    .sync (sck_sync),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_reg <= '0;
    end else begin
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // The synchronized level after an edge tells us its direction relative to CPOL.
  logic ss_edge, ss_start;
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;

  assign ss_edge     = ss_rise | ss_fall;
  assign ss_start    = ss_edge & ~ss_sync;
  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_sync != CPOL);
  assign trail_edge  = sck_edge & (sck_sync == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // Registered state
  spi_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] tx_buf_reg, tx_buf_next;
  logic              tx_empty_reg, tx_empty_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              spif_reg, spif_next;
  logic              ovr_reg, ovr_next;
  logic              miso_reg, miso_next;
  logic              miso_oe_reg, miso_oe_next;

  logic              do_load;
  logic [DATA_W-1:0] load_word;

  assign load_word = tx_empty_reg ? '0 : tx_buf_reg;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_buf_next   = tx_buf_reg;
    tx_empty_next = tx_empty_reg;
    rx_data_next  = rx_data_reg;
    spif_next     = spif_reg;
    ovr_next      = ovr_reg;
    miso_next     = miso_reg;
    miso_oe_next  = miso_oe_reg;
    do_load       = 1'b0;

    if (spif_clr) begin
      spif_next = 1'b0;
      ovr_next  = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        miso_next    = 1'b0;
        miso_oe_next = 1'b0;
        bit_cnt_next = '0;
        if (SPE && ss_start) begin
          do_load = 1'b1;
        end
      end

      ACTIVE: begin
        if (!SPE || ss_sync) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          miso_next    = 1'b0;
          miso_oe_next = 1'b0;
        end else if (sample_edge) begin
          shift_next   = LSBFE ? {mosi_s, shift_reg[DATA_W-1:1]}
                               : {shift_reg[DATA_W-2:0], mosi_s};
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next = DONE;
          end
        end else if (shift_edge) begin
          // Before the first sample this re-presents the first bit (CPHA=1 leading edge).
          miso_next = LSBFE ? shift_reg[0] : shift_reg[DATA_W-1];
        end
      end

      DONE: begin
        if (SPE) begin
          // A simultaneous spif_clr counts as already cleared, so the new frame is kept.
          if (!spif_reg || spif_clr) begin
            rx_data_next = shift_reg;
            spif_next    = 1'b1;
          end else begin
            ovr_next = 1'b1;
          end
        end
        if (!SPE || ss_sync) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          miso_next    = 1'b0;
          miso_oe_next = 1'b0;
        end else begin
          do_load = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (do_load) begin
      state_next    = ACTIVE;
      shift_next    = load_word;
      tx_empty_next = 1'b1;
      bit_cnt_next  = '0;
      miso_oe_next  = 1'b1;
      miso_next     = LSBFE ? load_word[0] : load_word[DATA_W-1];
    end

    // Evaluated against the pre-load flag so a write racing a frame start is kept for later.
    if (tx_load && tx_empty_reg) begin
      tx_buf_next   = tx_data;
      tx_empty_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_buf_reg   <= '0;
      tx_empty_reg <= 1'b1;
      rx_data_reg  <= '0;
      spif_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
      miso_reg     <= 1'b0;
      miso_oe_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_buf_reg   <= tx_buf_next;
      tx_empty_reg <= tx_empty_next;
      rx_data_reg  <= rx_data_next;
      spif_reg     <= spif_next;
      ovr_reg      <= ovr_next;
      miso_reg     <= miso_next;
      miso_oe_reg  <= miso_oe_next;
    end
  end

  assign MISO     = miso_reg;
  assign MISO_oe  = miso_oe_reg;
  assign tx_empty = tx_empty_reg;
  assign rx_data  = rx_data_reg;
  assign SPIF     = spif_reg;
  assign OVR      = ovr_reg;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Bench for spi_slave_resp: a behavioural SPI master drives frames in all modes and
// results are checked against a table and a scoreboard of expected outcomes.
module tb_spi_slave_resp;

  localparam int H = 6;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst, SPE, CPOL, CPHA, LSBFE, SS, SCK, MOSI, tx_load, spif_clr;
  logic [7:0] tx_data;
  logic       MISO, MISO_oe, tx_empty, SPIF, OVR;
  logic [7:0] rx_data;

  spi_slave_resp dut (
    .clk      (clk),
    .rst      (rst),
    .SPE      (SPE),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .LSBFE    (LSBFE),
    .SS       (SS),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_oe  (MISO_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_empty (tx_empty),
    .rx_data  (rx_data),
    .SPIF     (SPIF),
    .OVR      (OVR),
    .spif_clr (spif_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic       load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_master;
    logic [7:0] exp_seq;
  } vec_t;

  typedef struct {
    logic [7:0] rx_data;
    logic [7:0] master_rx;
    logic [7:0] seq;
  } exp_t;

  vec_t vecs [5];
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic pulse_clr();
    spif_clr = 1'b1;
    tick(1);
    spif_clr = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] val);
    tx_data = val;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic wait_spif(input string name);
    for (int k = 0; k < 40 && SPIF !== 1'b1; k++) tick(1);
    check(name, {7'd0, SPIF}, 8'h01);
  endtask

  // Behavioural master. stop_bits < 8 leaves the frame unfinished with SS still low.
  task automatic xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                      input logic lsbfe, input bit do_fall, input bit raise_ss,
                      input int stop_bits, input bit mid_load, input logic [7:0] mid_val,
                      output logic [7:0] rx, output logic [7:0] seq, output logic oe_seen);
    int idx;
    rx      = '0;
    seq     = '0;
    oe_seen = 1'b1;
    CPOL    = cpol;
    CPHA    = cpha;
    LSBFE   = lsbfe;
    SCK     = cpol;
    if (do_fall) begin
      tick(H);
      SS = 1'b0;
    end
    tick(H);
    for (int i = 0; i < stop_bits; i++) begin
      idx = lsbfe ? i : 7 - i;
      if (!cpha) begin
        MOSI = tx[idx];
        tick(2);
        SCK        = ~cpol;
        rx[idx]    = MISO;
        seq[7 - i] = MISO;
        oe_seen    = oe_seen & MISO_oe;
        tick(H);
        SCK = cpol;
        tick(H);
      end else begin
        SCK  = ~cpol;
        MOSI = tx[idx];
        tick(H);
        SCK        = cpol;
        rx[idx]    = MISO;
        seq[7 - i] = MISO;
        oe_seen    = oe_seen & MISO_oe;
        tick(H);
      end
      if (mid_load && i == 3) begin
        load_tx(mid_val);
        check("tx_load_mid_frame_tx_empty", {7'd0, tx_empty}, 8'h00);
      end
    end
    if (raise_ss) begin
      SS = 1'b1;
      tick(H + 2);
    end
  endtask

  initial begin
    logic [7:0] mrx, seq;
    logic       oe;
    exp_t       e;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'hF0, 8'h81, 8'h81};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h96, 8'h5A, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'hE1, 8'h0F, 8'hF0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h7E, 8'h00, 8'h00};

    rst = 1'b1; SPE = 1'b1; CPOL = 1'b0; CPHA = 1'b0; LSBFE = 1'b0;
    SS = 1'b1; SCK = 1'b0; MOSI = 1'b0; tx_load = 1'b0; tx_data = '0; spif_clr = 1'b0;
    tick(3);
    check("reset_MISO", {7'd0, MISO}, 8'h00);
    check("reset_MISO_oe", {7'd0, MISO_oe}, 8'h00);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_SPIF", {7'd0, SPIF}, 8'h00);
    check("reset_OVR", {7'd0, OVR}, 8'h00);
    check("reset_tx_empty", {7'd0, tx_empty}, 8'h01);
    rst = 1'b0;
    tick(2);

    // Table-driven frames across all four modes and both bit orders.
    for (int v = 0; v < 5; v++) begin
      pulse_clr();
      if (vecs[v].load) begin
        load_tx(vecs[v].tx);
        check($sformatf("v%0d_tx_empty_after_load", v), {7'd0, tx_empty}, 8'h00);
      end
      sb.push_back('{vecs[v].mosi, vecs[v].exp_master, vecs[v].exp_seq});
      xfer(vecs[v].mosi, vecs[v].cpol, vecs[v].cpha, vecs[v].lsbfe, 1'b1, 1'b1, 8,
           1'b0, 8'h00, mrx, seq, oe);
      wait_spif($sformatf("v%0d_spif", v));
      e = sb.pop_front();
      check($sformatf("v%0d_rx_data", v), rx_data, e.rx_data);
      check($sformatf("v%0d_master_rx", v), mrx, e.master_rx);
      check($sformatf("v%0d_miso_order", v), seq, e.seq);
      check($sformatf("v%0d_oe_during_frame", v), {7'd0, oe}, 8'h01);
      check($sformatf("v%0d_ovr", v), {7'd0, OVR}, 8'h00);
      check($sformatf("v%0d_tx_empty", v), {7'd0, tx_empty}, 8'h01);
      check($sformatf("v%0d_oe_after_ss", v), {7'd0, MISO_oe}, 8'h00);
    end

    // Overrun: second frame lands while SPIF is still set.
    pulse_clr();
    xfer(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0, 8'h00, mrx, seq, oe);
    wait_spif("ovr_first_spif");
    xfer(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0, 8'h00, mrx, seq, oe);
    check("ovr_rx_data_kept", rx_data, 8'h11);
    check("ovr_spif", {7'd0, SPIF}, 8'h01);
    check("ovr_flag", {7'd0, OVR}, 8'h01);
    pulse_clr();
    check("ovr_clr_spif", {7'd0, SPIF}, 8'h00);
    check("ovr_clr_ovr", {7'd0, OVR}, 8'h00);

    // Aborted frame after 4 bits, then a full frame.
    xfer(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0, 8'h00, mrx, seq, oe);
    SS = 1'b1;
    tick(H + 2);
    check("abort_no_spif", {7'd0, SPIF}, 8'h00);
    check("abort_oe_low", {7'd0, MISO_oe}, 8'h00);
    xfer(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0, 8'h00, mrx, seq, oe);
    wait_spif("after_abort_spif");
    check("after_abort_rx_data", rx_data, 8'h55);

    // Empty buffer at SS fall; a mid-frame load feeds the next frame with SS held low.
    pulse_clr();
    check("empty_before_frame", {7'd0, tx_empty}, 8'h01);
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 1'b1, 8'h9C, mrx, seq, oe);
    check("empty_master_rx", mrx, 8'h00);
    wait_spif("empty_spif");
    check("empty_rx_data", rx_data, 8'h3C);
    pulse_clr();
    xfer(8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 8'h00, mrx, seq, oe);
    check("held_master_rx", mrx, 8'h9C);
    wait_spif("held_spif");
    check("held_rx_data", rx_data, 8'h66);

    // Reset pulse in the middle of a frame.
    load_tx(8'h3C);
    xfer(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 8'h00, mrx, seq, oe);
    rst = 1'b1;
    tick(1);
    check("midrst_MISO", {7'd0, MISO}, 8'h00);
    check("midrst_MISO_oe", {7'd0, MISO_oe}, 8'h00);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_SPIF", {7'd0, SPIF}, 8'h00);
    check("midrst_OVR", {7'd0, OVR}, 8'h00);
    check("midrst_tx_empty", {7'd0, tx_empty}, 8'h01);
    rst = 1'b0;
    SS  = 1'b1;
    tick(H);
    load_tx(8'h5A);
    xfer(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0, 8'h00, mrx, seq, oe);
    wait_spif("postrst_spif");
    check("postrst_rx_data", rx_data, 8'hC3);
    check("postrst_master_rx", mrx, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
